// File: rtl/dpram_stream_reader_if.sv
// Stream-reader bus: burst control, RAM read port and output stream.
interface dpram_stream_reader_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 18
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] length;
    logic              abort;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;

    modport master (output start, start_addr, length, abort, q, m_ready,
                    input  rdaddress, m_data, m_valid, m_last, busy, done);
    modport slave  (input  start, start_addr, length, abort, q, m_ready,
                    output rdaddress, m_data, m_valid, m_last, busy, done);
endinterface

// File: rtl/dpram_stream_reader.sv
// Burst reader: walks a circular RAM region and streams the words out
// through a 2-entry FIFO with valid/ready handshake.
module dpram_stream_reader #(
    parameter int DEPTH  = 200000,
    parameter int DATA_W = 14,
    parameter int ADDR_W = 18
) (
    input logic                  clock,
    input logic                  aclr,
    dpram_stream_reader_if.slave bus
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d, rem_q, rem_d;
    logic              rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
    logic              done_q, done_d;
    logic              cap_q, cap_last_q;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_last_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q;

    logic [ADDR_W-1:0] eff_addr, eff_len, next_addr;
    logic              pop, capture, room, last_hs;

    assign eff_addr  = (bus.start_addr >= DEPTH_A) ? '0 : bus.start_addr;
    assign eff_len   = (bus.length > DEPTH_A) ? DEPTH_A : bus.length;
    assign next_addr = (rdaddr_q == LAST_A) ? '0 : rdaddr_q + ONE_A;

    assign bus.m_valid   = (cnt_q != 2'd0);
    assign bus.m_data    = fifo_data_q[rd_ptr_q];
    assign bus.m_last    = bus.m_valid & fifo_last_q[rd_ptr_q];
    assign bus.rdaddress = rdaddr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

    assign pop     = bus.m_valid & bus.m_ready;
    assign last_hs = pop & bus.m_last;
    // A word on q stays valid while rdaddress is unchanged, so it may wait there
    // for a free FIFO slot; no new read is issued until it is taken.
    assign capture = cap_q & ((cnt_q != 2'd2) | pop);
    assign room    = ({1'b0, cnt_q} + {2'b00, cap_q} - {2'b00, pop}) <= 3'd1;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rdaddr_d  = rdaddr_q;
        rem_d     = rem_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (eff_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        rdaddr_d  = eff_addr;
                        rem_d     = eff_len - ONE_A;
                        rd_vld_d  = 1'b1;
                        rd_last_d = (eff_len == ONE_A);
                    end
                end
            end
            RUN: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else if (room) begin
                    rdaddr_d  = next_addr;
                    rem_d     = rem_q - ONE_A;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (rem_q == ONE_A);
                    if (rem_q == ONE_A) state_d = DRAIN;
                end
            end
            DRAIN:   ;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && last_hs) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        if (bus.abort) begin
            state_d   = IDLE;
            rdaddr_d  = rdaddr_q;
            rem_d     = rem_q;
            rd_vld_d  = 1'b0;
            rd_last_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rdaddr_q    <= '0;
            rem_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            cap_q       <= 1'b0;
            cap_last_q  <= 1'b0;
            cnt_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_last_q <= 2'b00;
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
        end else begin
            rdaddr_q  <= rdaddr_d;
            rem_q     <= rem_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            done_q    <= done_d;
            if (bus.abort) begin
                cap_q      <= 1'b0;
                cap_last_q <= 1'b0;
                cnt_q      <= 2'd0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
            end else begin
                if (rd_vld_q) begin
                    cap_q      <= 1'b1;
                    cap_last_q <= rd_last_q;
                end else if (capture) begin
                    cap_q      <= 1'b0;
                    cap_last_q <= 1'b0;
                end
                if (capture) begin
                    fifo_data_q[wr_ptr_q] <= bus.q;
                    fifo_last_q[wr_ptr_q] <= cap_last_q;
                    wr_ptr_q              <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                cnt_q <= cnt_q + {1'b0, capture} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench: full-size reader for latency/wrap/backpressure/abort/reset,
// plus a small-DEPTH reader for length clamping over a whole region.
module tb_dpram_stream_reader;
    localparam int DEPTH = 200000, DATA_W = 14, ADDR_W = 18;
    localparam int S_DEPTH = 20, S_DW = 8, S_AW = 8;

    logic clock = 1'b0;
    logic aclr  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dpram_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    dpram_stream_reader_if #(.DATA_W(S_DW), .ADDR_W(S_AW)) sbus ();

    dpram_stream_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W))
        u_dut (.clock(clock), .aclr(aclr), .bus(bus.slave));
    dpram_stream_reader #(.DEPTH(S_DEPTH), .DATA_W(S_DW), .ADDR_W(S_AW))
        u_small (.clock(clock), .aclr(aclr), .bus(sbus.slave));

    always #5 clock = ~clock;

    // RAMs preloaded with mem[i]=i: read data is the address cut to word width
    always @(posedge clock) begin
        bus.q  <= DATA_W'(bus.rdaddress);
        sbus.q <= S_DW'(sbus.rdaddress);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.rdaddress !== '0 || bus.m_data !== '0 || bus.m_valid !== 1'b0 ||
            bus.m_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: addr=%0d data=%0d v=%0b l=%0b busy=%0b done=%0b, want all 0",
                     bus.rdaddress, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.done);
        end
        tick();
        total++;
        if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || sbus.busy !== 1'b0 || sbus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: v=%0b busy=%0b sv=%0b sbusy=%0b, want 0",
                     bus.m_valid, bus.busy, sbus.m_valid, sbus.busy);
        end
        aclr = 1'b0;
    endtask

    // Caller is positioned in "cycle 0"; start is raised immediately.
    task automatic test_basic(input string tag);
        logic [DATA_W-1:0] exp_d;
        bus.m_ready = 1'b1; bus.start_addr = 18'd10; bus.length = 18'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.rdaddress !== 18'd10 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_c1: addr=%0d busy=%0b, want addr=10 busy=1", tag, bus.rdaddress, bus.busy);
        end
        tick();
        total++;
        if (bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_c2: valid=%0b, want 0", tag, bus.m_valid);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_d = DATA_W'(10 + k);
            total++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d || bus.m_last !== (k == 3)) begin
                bad++;
                $display("FAIL %s_word%0d: v=%0b data=%0d last=%0b, want v=1 data=%0d last=%0b",
                         tag, k, bus.m_valid, bus.m_data, bus.m_last, exp_d, (k == 3));
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_c7: done=%0b busy=%0b v=%0b, want 1 0 0", tag, bus.done, bus.busy, bus.m_valid);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL %s_c8: done=%0b, want 0", tag, bus.done);
        end
    endtask

    task automatic test_wrap();
        int exp_a [4] = '{199998, 199999, 0, 1};
        bus.start_addr = 18'(199998); bus.length = 18'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                total++;
                if (bus.rdaddress !== 18'(exp_a[c-1])) begin
                    bad++;
                    $display("FAIL wrap_addr_c%0d: got %0d, want %0d", c, bus.rdaddress, exp_a[c-1]);
                end
            end
            if (c >= 3 && c <= 6) begin
                total++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== DATA_W'(exp_a[c-3]) || bus.m_last !== (c == 6)) begin
                    bad++;
                    $display("FAIL wrap_data_c%0d: v=%0b data=%0d last=%0b, want data=%0d",
                             c, bus.m_valid, bus.m_data, bus.m_last, DATA_W'(exp_a[c-3]));
                end
            end
            if (c == 7) begin
                total++;
                if (bus.done !== 1'b1) begin
                    bad++;
                    $display("FAIL wrap_done: got %0b, want 1", bus.done);
                end
            end
            tick();
        end
    endtask

    task automatic test_bad_addr();
        bus.start_addr = 18'(250000); bus.length = 18'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.rdaddress !== '0) begin
            bad++;
            $display("FAIL badaddr_c1: addr=%0d, want 0", bus.rdaddress);
        end
        tick(); tick();
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== '0 || bus.m_last !== 1'b0) begin
            bad++;
            $display("FAIL badaddr_w0: v=%0b data=%0d last=%0b, want 1 0 0", bus.m_valid, bus.m_data, bus.m_last);
        end
        tick();
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== DATA_W'(1) || bus.m_last !== 1'b1) begin
            bad++;
            $display("FAIL badaddr_w1: v=%0b data=%0d last=%0b, want 1 1 1", bus.m_valid, bus.m_data, bus.m_last);
        end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int                got = 0;
        int                dones = 0;
        logic              stalled = 1'b0;
        logic [DATA_W-1:0] held = '0;
        bus.start_addr = 18'd100; bus.length = 18'd8; bus.m_ready = 1'b1; bus.start = 1'b1;
        tick();
        for (int c = 1; c < 60 && dones == 0; c++) begin
            // a start during the burst must not disturb it
            if (c == 2) begin
                bus.start = 1'b1; bus.start_addr = 18'd0; bus.length = 18'd1;
            end else begin
                bus.start = 1'b0;
            end
            bus.m_ready = (c % 3 == 0);
            if (stalled) begin
                total++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
                    bad++;
                    $display("FAIL bp_stall_c%0d: v=%0b data=%0d, want v=1 data=%0d", c, bus.m_valid, bus.m_data, held);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                total++;
                if (bus.m_data !== DATA_W'(100 + got) || bus.m_last !== (got == 7)) begin
                    bad++;
                    $display("FAIL bp_word%0d: data=%0d last=%0b, want data=%0d last=%0b",
                             got, bus.m_data, bus.m_last, 100 + got, (got == 7));
                end
                got++;
            end
            stalled = bus.m_valid & ~bus.m_ready;
            held    = bus.m_data;
            if (bus.done) dones++;
            tick();
        end
        bus.m_ready = 1'b1;
        total++;
        if (got != 8 || dones != 1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_count: words=%0d dones=%0d busy=%0b, want 8 1 0", got, dones, bus.busy);
        end
        tick();
    endtask

    task automatic test_zero_len();
        bus.start_addr = 18'd5; bus.length = 18'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_c1: done=%0b busy=%0b v=%0b, want 1 0 0", bus.done, bus.busy, bus.m_valid);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_c%0d: done=%0b busy=%0b v=%0b, want 0 0 0", c, bus.done, bus.busy, bus.m_valid);
            end
        end
        tick();
    endtask

    task automatic test_abort();
        bus.start_addr = 18'd50; bus.length = 18'd10; bus.m_ready = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== DATA_W'(52)) begin
            bad++;
            $display("FAIL abort_hs3: v=%0b data=%0d, want 1 52", bus.m_valid, bus.m_data);
        end
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL abort_after%0d: v=%0b busy=%0b done=%0b, want 0 0 0", c, bus.m_valid, bus.busy, bus.done);
            end
            tick();
        end
        bus.start_addr = 18'd20; bus.length = 18'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.rdaddress !== 18'd20) begin
            bad++;
            $display("FAIL abort_restart_addr: got %0d, want 20", bus.rdaddress);
        end
        tick();
        total++;
        if (bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart_c2: v=%0b, want 0", bus.m_valid);
        end
        tick();
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== DATA_W'(20)) begin
            bad++;
            $display("FAIL abort_restart_c3: v=%0b data=%0d, want 1 20", bus.m_valid, bus.m_data);
        end
        repeat (3) tick();
    endtask

    task automatic test_abort_start();
        bus.abort = 1'b1; bus.start = 1'b1; bus.start_addr = 18'd7; bus.length = 18'd3;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total++;
            if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL abortstart_c%0d: busy=%0b v=%0b done=%0b, want 0 0 0", c, bus.busy, bus.m_valid, bus.done);
            end
            tick();
        end
    endtask

    task automatic test_aclr();
        bus.start_addr = 18'd30; bus.length = 18'd10; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        #2 aclr = 1'b1;
        #1;
        total++;
        if (bus.rdaddress !== '0 || bus.m_data !== '0 || bus.m_valid !== 1'b0 ||
            bus.m_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL aclr_mid: addr=%0d data=%0d v=%0b l=%0b busy=%0b done=%0b, want all 0",
                     bus.rdaddress, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.done);
        end
        tick();
        aclr = 1'b0;
        test_basic("aclr_restart");
    endtask

    task automatic test_clamp();
        int   got = 0;
        int   dones = 0;
        sbus.m_ready = 1'b1; sbus.start_addr = 8'd15; sbus.length = 8'd255; sbus.start = 1'b1;
        tick();
        sbus.start = 1'b0;
        for (int c = 1; c < 60 && dones == 0; c++) begin
            if (sbus.m_valid) begin
                total++;
                if (sbus.m_data !== S_DW'((15 + got) % S_DEPTH) || sbus.m_last !== (got == S_DEPTH - 1)) begin
                    bad++;
                    $display("FAIL clamp_word%0d: data=%0d last=%0b, want data=%0d",
                             got, sbus.m_data, sbus.m_last, (15 + got) % S_DEPTH);
                end
                got++;
            end
            if (sbus.done) dones++;
            tick();
        end
        total++;
        if (got != S_DEPTH || dones != 1) begin
            bad++;
            $display("FAIL clamp_count: words=%0d dones=%0d, want %0d 1", got, dones, S_DEPTH);
        end
        sbus.start_addr = 8'd25; sbus.length = 8'd3; sbus.start = 1'b1;
        tick();
        sbus.start = 1'b0;
        total++;
        if (sbus.rdaddress !== 8'd0) begin
            bad++;
            $display("FAIL clamp_badaddr: addr=%0d, want 0", sbus.rdaddress);
        end
        repeat (8) tick();
    endtask

    initial begin
        bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.abort = 1'b0; bus.m_ready = 1'b1;
        sbus.start = 1'b0; sbus.start_addr = '0; sbus.length = '0; sbus.abort = 1'b0; sbus.m_ready = 1'b1;
        test_reset();
        tick();
        test_basic("basic");
        test_wrap();
        test_bad_addr();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_abort_start();
        test_aclr();
        test_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
